mem_responder: RTL and testbench
================================

# mem_responder

Byte-wide memory target on the far side of the CPU's memory controller port. It serves the `ad`/`wd`/`we`/`rd` byte interface with a synchronous-read RAM and a small memory-mapped I/O window. The window holds a transmit byte FIFO that drains through a valid/ready stream, plus a free-running 32-bit cycle counter with a coherent multi-byte read. The controller's multi-cycle lh/lw/sh/sw sequences map onto consecutive single-byte accesses here without change.

## Interface
- `MABL`, 19, address width in bits; must match the controller.
- `DEPTH_L2`, 16, log2 of RAM size in bytes; `DEPTH_L2` < `MABL`.
- `FIFO_L2`, 3, log2 of TX FIFO depth (8 entries).
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ad`  input  MABL  byte address from the controller.
- `wd`  input  8  write byte.
- `we`  input  1  write enable, sampled at the rising edge.
- `rd`  output  8  read byte for the address sampled at the previous edge.
- `tx_data`  output  8  FIFO head byte.
- `tx_valid`  output  1  FIFO not empty.
- `tx_ready`  input  1  sink accepts `tx_data` when `tx_valid` && `tx_ready` at an edge.

## Operation
- Decode uses `ad[MABL-1]`:
  - 0 selects RAM, indexed by `ad[DEPTH_L2-1:0]`. Higher RAM address bits alias.
  - 1 selects MMIO, decoded on `ad[2:0]`. Other bits are ignored.
- RAM:
  - A write stores `wd` at the edge when `we`=1.
  - A read is read-first: if the same address is written at the same edge, `rd` returns the old byte.
  - RAM contents are not reset.
- MMIO map:
  - 0 TXDATA: a write pushes `wd` into the FIFO. Reads return 0x00.
  - 1 STATUS: read returns {5'b0, overflow, full, empty}. Any write clears `overflow`.
  - 2, 3 reserved: reads return 0x00, writes are ignored.
  - 4 CNT0: a read returns `cnt[7:0]` and, at the same edge, latches `cnt[31:8]` into `snap`.
  - 5, 6, 7 CNT1..CNT3: reads return `snap[7:0]`, `snap[15:8]`, `snap[23:16]` respectively.
  - Writes to 4..7 are ignored.
- Because reading CNT0 latches `snap`, the controller's lw at MMIO offset 4 (bytes 4,5,6,7 in order) returns a coherent 32-bit value.
- A read means any cycle with `we`=0; the controller drives addresses only during accesses, so the side effect of reading CNT0 is acceptable.
- `cnt` increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- FIFO:
  - Circular buffer with `FIFO_L2`+1-bit read and write pointers.
  - Empty when the pointers are equal; full when the MSBs differ and the low bits are equal.
  - Pop on `tx_valid` && `tx_ready`.
  - A push while full and without a simultaneous pop drops the byte and sets sticky `overflow`.
  - A push while full with a simultaneous pop is accepted.
  - A push while empty is accepted; `tx_valid` is 0 that cycle, so no pop occurs.

## Timing
- Reset values:
  - Outputs: `rd`=0x00, `tx_valid`=0, `tx_data`=0x00.
  - State: both FIFO pointers 0, `overflow`=0, `cnt`=0, `snap`=0.
- Read latency is 1 cycle: `ad` sampled at edge N gives `rd` valid after edge N, ready for the controller's use in cycle N+1.
- `rd` updates every cycle regardless of `we`.
- `tx_data`/`tx_valid` are combinational from the FIFO state.
  - A pushed byte appears on `tx_valid` in the cycle after the write edge.
  - `tx_data` is held stable while `tx_valid`=1 and `tx_ready`=0.
- STATUS reflects FIFO state as of the read edge, i.e. it excludes a push at that same edge.
- `cnt` is 0 in the first cycle after reset release and 1 after the following edge.
- Reset asserted mid-access or mid-FIFO-drain:
  - All registers return to reset values immediately.
  - Queued bytes are discarded.
  - RAM is untouched.

## Test plan
- Write 0xA5 to RAM 0x00010 with `we`=1, then read 0x00010 → `rd`=0xA5 one cycle later; read 0x10010 (alias, DEPTH_L2=16) also → 0xA5.
- Same-edge write of 0x3C to 0x00020 (old value 0x11) with a read of 0x00020 → `rd`=0x11; next read → 0x3C.
- With `tx_ready`=0, push 0x01..0x09 (nine bytes) → STATUS reads 0x06 (full, overflow). Raise `tx_ready` → `tx_data` sequence 0x01..0x08 on consecutive cycles, then `tx_valid`=0; STATUS reads 0x05. Write STATUS → STATUS reads 0x01.
- FIFO full with `tx_ready`=1, push 0x77 → no overflow, 0x77 emitted last.
- Release reset, wait until `cnt`=0x000000FF, then issue byte reads 4,5,6,7 → 0xFF,0x00,0x00,0x00 (no tearing despite `cnt` carrying into bit 8).
- Assert `rst_n`=0 with 3 bytes queued → `tx_valid`=0, `rd`=0x00, STATUS=0x01 after release; RAM content from the first test is intact.

Source files
------------

// File: rtl/mem_responder_if.sv
// Byte-wide memory target bus: controller address/data/strobe, read-back
// byte and the transmit stream that drains the MMIO FIFO.
interface mem_responder_if #(
    parameter int MABL = 19
);
    logic [MABL-1:0] ad;
    logic [7:0]      wd;
    logic            we;
    logic [7:0]      rd;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;

    // Controller plus stream sink side
    modport master (
        output ad, wd, we, tx_ready,
        input  rd, tx_data, tx_valid
    );

    // Memory target side
    modport slave (
        input  ad, wd, we, tx_ready,
        output rd, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_responder.sv
// Byte memory target: synchronous read-first RAM in the lower half of the
// address space, MMIO window (TX FIFO, status, snapshot cycle counter) in
// the upper half. Read data is one cycle behind the sampled address.
module mem_responder #(
    parameter int MABL     = 19,
    parameter int DEPTH_L2 = 16,
    parameter int FIFO_L2  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_responder_if.slave bus
);
    localparam int FDEPTH = 1 << FIFO_L2;

    // RAM storage and its registered read byte (no reset so it maps to BRAM)
    logic [7:0]          r_mem [0:(1<<DEPTH_L2)-1];
    logic [7:0]          r_ram_q;

    // Read-back path: which source the previous edge sampled, MMIO byte
    logic                r_sel_ram;
    logic [7:0]          r_mmio_q;

    // TX FIFO with one extra pointer bit to tell full from empty
    logic [7:0]          r_fifo [0:FDEPTH-1];
    logic [FIFO_L2:0]    r_wptr;
    logic [FIFO_L2:0]    r_rptr;
    logic                r_overflow;

    // Free-running counter and the upper bytes frozen by a CNT0 read
    logic [31:0]         r_cnt;
    logic [23:0]         r_snap;

    logic                w_is_mmio;
    logic [2:0]          w_off;
    logic [DEPTH_L2-1:0] w_ram_idx;
    logic                w_ram_we;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic                w_cnt0_rd;
    logic [7:0]          w_mmio_rdata;

    assign w_is_mmio  = bus.ad[MABL-1];
    assign w_off      = bus.ad[2:0];
    assign w_ram_idx  = bus.ad[DEPTH_L2-1:0];
    assign w_ram_we   = bus.we & ~w_is_mmio;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[FIFO_L2] != r_rptr[FIFO_L2]) &&
                        (r_wptr[FIFO_L2-1:0] == r_rptr[FIFO_L2-1:0]);
    assign w_pop      = ~w_empty & bus.tx_ready;

    // A push into a full FIFO only lands if the head leaves at the same edge;
    // the freed slot is exactly the one the write pointer addresses.
    assign w_push_req = bus.we & w_is_mmio & (w_off == 3'd0);
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = bus.we & w_is_mmio & (w_off == 3'd1);

    // Any non-write cycle at CNT0 counts as a read and freezes the upper bytes
    assign w_cnt0_rd  = ~bus.we & w_is_mmio & (w_off == 3'd4);

    // Address bits between the RAM index and the decode bit alias away
    generate
        if (DEPTH_L2 < MABL - 1) begin : g_alias
            logic w_unused_alias;
            assign w_unused_alias = &{1'b0, bus.ad[MABL-2:DEPTH_L2]};
        end
    endgenerate

    // MMIO read byte from state as it stands before this edge's updates
    always_comb begin
        w_mmio_rdata = 8'h00;
        case (w_off)
            3'd1:    w_mmio_rdata = {5'b0, r_overflow, w_full, w_empty};
            3'd4:    w_mmio_rdata = r_cnt[7:0];
            3'd5:    w_mmio_rdata = r_snap[7:0];
            3'd6:    w_mmio_rdata = r_snap[15:8];
            3'd7:    w_mmio_rdata = r_snap[23:16];
            default: w_mmio_rdata = 8'h00;
        endcase
    end

    // RAM write plus read-first registered read, every cycle
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= bus.wd;
        end
        r_ram_q <= r_mem[w_ram_idx];
    end

    // FIFO storage write for accepted pushes
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[FIFO_L2-1:0]] <= bus.wd;
        end
    end

    // Read-back source select and MMIO read byte register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_ram <= 1'b0;
            r_mmio_q  <= 8'h00;
        end else begin
            r_sel_ram <= ~w_is_mmio;
            r_mmio_q  <= w_mmio_rdata;
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Cycle counter and coherent snapshot of its upper three bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 32'h0;
            r_snap <= 24'h0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_cnt0_rd) begin
                r_snap <= r_cnt[31:8];
            end
        end
    end

    assign bus.rd       = r_sel_ram ? r_ram_q : r_mmio_q;
    assign bus.tx_valid = ~w_empty;
    assign bus.tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr[FIFO_L2-1:0]];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table covering RAM and FIFO
// behaviour, then hand sequences for reset mid-drain and counter snapshot.
module tb_mem_responder;
    localparam logic [18:0] MM = 19'h40000;

    typedef struct {
        logic        we;
        logic [18:0] ad;
        logic [7:0]  wd;
        logic        rdy;
        logic        crd;
        logic [7:0]  erd;
        logic        ctx;
        logic        ev;
        logic [7:0]  ed;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    mem_responder_if #(.MABL(19)) bus ();

    mem_responder #(.MABL(19), .DEPTH_L2(16), .FIFO_L2(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(logic we, logic [18:0] ad, logic [7:0] wd,
                                 logic rdy, logic crd, logic [7:0] erd,
                                 logic ctx, logic ev, logic [7:0] ed);
        vec_t v;
        v.we = we; v.ad = ad; v.wd = wd; v.rdy = rdy;
        v.crd = crd; v.erd = erd; v.ctx = ctx; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic check(input int idx, input string nm,
                         input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %02h want %02h", idx, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        bus.we       = v.we;
        bus.ad       = v.ad;
        bus.wd       = v.wd;
        bus.tx_ready = v.rdy;
        @(posedge clk);
        #1;
        $display("[TB] step %0d we=%0b ad=%05h wd=%02h rdy=%0b -> rd=%02h v=%0b d=%02h",
                 idx, v.we, v.ad, v.wd, v.rdy, bus.rd, bus.tx_valid, bus.tx_data);
        if (v.crd) check(idx, "rd", bus.rd, v.erd);
        if (v.ctx) begin
            check(idx, "tx_valid", {7'b0, bus.tx_valid}, {7'b0, v.ev});
            if (v.ev) check(idx, "tx_data", bus.tx_data, v.ed);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n        = 1'b0;
        bus.we       = 1'b0;
        bus.ad       = '0;
        bus.wd       = 8'h00;
        bus.tx_ready = 1'b0;

        // ---- vector table ----
        // RAM write, read, alias read
        vecs.push_back(mkv(1, 19'h00010, 8'hA5, 0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mkv(0, 19'h00010, 8'h00, 0, 1, 8'hA5, 1, 0, 8'h00));
        vecs.push_back(mkv(0, 19'h10010, 8'h00, 0, 1, 8'hA5, 0, 0, 8'h00));
        // Read-first on same-edge write
        vecs.push_back(mkv(1, 19'h00020, 8'h11, 0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mkv(1, 19'h00020, 8'h3C, 0, 1, 8'h11, 0, 0, 8'h00));
        vecs.push_back(mkv(0, 19'h00020, 8'h00, 0, 1, 8'h3C, 0, 0, 8'h00));
        // Push 01..08 with sink stalled
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkv(1, MM, 8'(k), 0, 1, 8'h00, 1, 1, 8'h01));
        // Full, no overflow yet
        vecs.push_back(mkv(0, MM + 19'd1, 8'h00, 0, 1, 8'h02, 1, 1, 8'h01));
        // Ninth push is dropped
        vecs.push_back(mkv(1, MM, 8'h09, 0, 0, 8'h00, 1, 1, 8'h01));
        vecs.push_back(mkv(0, MM + 19'd1, 8'h00, 0, 1, 8'h06, 1, 1, 8'h01));
        // Drain: head after each pop is 02..08, then empty
        for (int k = 2; k <= 9; k++)
            vecs.push_back(mkv(0, 19'h00010, 8'h00, 1, 1, 8'hA5, 1, (k <= 8), 8'(k)));
        vecs.push_back(mkv(0, MM + 19'd1, 8'h00, 0, 1, 8'h05, 1, 0, 8'h00));
        // Write STATUS clears overflow
        vecs.push_back(mkv(1, MM + 19'd1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mkv(0, MM + 19'd1, 8'h00, 0, 1, 8'h01, 1, 0, 8'h00));
        // Fill with 10..17, then push 77 while full with a pop
        for (int k = 0; k < 8; k++)
            vecs.push_back(mkv(1, MM, 8'(8'h10 + k), 0, 0, 8'h00, 1, 1, 8'h10));
        vecs.push_back(mkv(1, MM, 8'h77, 1, 0, 8'h00, 1, 1, 8'h11));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mkv(0, 19'h00020, 8'h00, 1, 1, 8'h3C, 1, 1, 8'(8'h12 + k)));
        vecs.push_back(mkv(0, 19'h00020, 8'h00, 1, 1, 8'h3C, 1, 1, 8'h77));
        vecs.push_back(mkv(0, 19'h00020, 8'h00, 1, 1, 8'h3C, 1, 0, 8'h00));
        vecs.push_back(mkv(0, MM + 19'd1, 8'h00, 0, 1, 8'h01, 1, 0, 8'h00));
        // Reserved offsets read zero, writes ignored
        vecs.push_back(mkv(1, MM + 19'd2, 8'hFF, 0, 0, 8'h00, 1, 0, 8'h00));
        vecs.push_back(mkv(0, MM + 19'd2, 8'h00, 0, 1, 8'h00, 1, 0, 8'h00));
        vecs.push_back(mkv(0, MM + 19'd3, 8'h00, 0, 1, 8'h00, 1, 0, 8'h00));
        // Queue three bytes, then leave rd showing RAM data
        vecs.push_back(mkv(1, MM, 8'hAA, 0, 0, 8'h00, 1, 1, 8'hAA));
        vecs.push_back(mkv(1, MM, 8'hBB, 0, 0, 8'h00, 1, 1, 8'hAA));
        vecs.push_back(mkv(1, MM, 8'hCC, 0, 0, 8'h00, 1, 1, 8'hAA));
        vecs.push_back(mkv(0, 19'h00010, 8'h00, 0, 1, 8'hA5, 1, 1, 8'hAA));

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check(0, "reset rd", bus.rd, 8'h00);
        check(0, "reset tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        check(0, "reset tx_data", bus.tx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i + 1);

        // ---- reset mid-drain: asynchronous clear, RAM kept ----
        @(negedge clk);
        bus.we = 1'b0; bus.ad = 19'h00000; bus.tx_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check(100, "async rst rd", bus.rd, 8'h00);
        check(100, "async rst tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(101, "post rst tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        check(101, "post rst rd", bus.rd, 8'h00);
        apply(mkv(0, MM + 19'd1, 8'h00, 0, 1, 8'h01, 1, 0, 8'h00), 102);
        apply(mkv(0, 19'h00010, 8'h00, 0, 1, 8'hA5, 1, 0, 8'h00), 103);
        apply(mkv(0, 19'h00020, 8'h00, 0, 1, 8'h3C, 1, 0, 8'h00), 104);

        // ---- counter snapshot across the byte-0 carry ----
        @(negedge clk);
        bus.we = 1'b0; bus.ad = 19'h00000; bus.tx_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Edge k after release samples cnt = k-1; edge 256 sees 0xFF
        repeat (255) @(posedge clk);
        apply(mkv(0, MM + 19'd4, 8'h00, 0, 1, 8'hFF, 0, 0, 8'h00), 200);
        apply(mkv(0, MM + 19'd5, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00), 201);
        apply(mkv(0, MM + 19'd6, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00), 202);
        apply(mkv(0, MM + 19'd7, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00), 203);
        // Edge 260 sees 0x103; snapshot now holds 0x000001
        apply(mkv(0, MM + 19'd4, 8'h00, 0, 1, 8'h03, 0, 0, 8'h00), 204);
        apply(mkv(0, MM + 19'd5, 8'h00, 0, 1, 8'h01, 0, 0, 8'h00), 205);
        apply(mkv(0, MM + 19'd6, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00), 206);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
